// File: rtl/baby_control_unit.sv
// baby_control_unit: Manchester Baby fetch/decode/execute sequencer.
// All arithmetic is routed through one external subtractor.
module baby_control_unit #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic [DATA_W-1:0] sub_a,
    output logic [DATA_W-1:0] sub_b,
    output logic              sub_borrow_in,
    input  logic [DATA_W-1:0] sub_result,
    input  logic              sub_borrow_out,
    output logic [DATA_W-1:0] acc,
    output logic [DATA_W-1:0] ci,
    output logic              halted,
    output logic              overflow_dbg
);
    localparam logic [2:0] HALT  = 3'd0;
    localparam logic [2:0] INC   = 3'd1;
    localparam logic [2:0] FETCH = 3'd2;
    localparam logic [2:0] OPER  = 3'd3;
    localparam logic [2:0] EXEC  = 3'd4;
    localparam logic [2:0] EXEC2 = 3'd5;
    localparam logic [2:0] STORE = 3'd6;

    localparam logic [2:0] OP_JMP = 3'd0;
    localparam logic [2:0] OP_JRP = 3'd1;
    localparam logic [2:0] OP_LDN = 3'd2;
    localparam logic [2:0] OP_STO = 3'd3;
    localparam logic [2:0] OP_CMP = 3'd6;
    localparam logic [2:0] OP_STP = 3'd7;

    logic [2:0]        state;
    logic [DATA_W-1:0] pi;
    logic [DATA_W-1:0] t;
    logic [2:0]        f;
    logic [2:0]        fn;
    logic              is_sub;
    logic              is_cmp;

    // Baby bit order: function bits are reversed within PI[15:13]
    assign f      = {pi[13], pi[14], pi[15]};
    assign fn     = {mem_rdata[13], mem_rdata[14], mem_rdata[15]};
    assign is_sub = f[2:1] == 2'b10;
    assign is_cmp = state == EXEC && f == OP_CMP;

    assign halted        = state == HALT;
    assign mem_rd        = state == FETCH || state == OPER;
    assign mem_wr        = state == STORE;
    assign mem_addr      = state == FETCH ? ci[ADDR_W-1:0] : pi[ADDR_W-1:0];
    assign mem_wdata     = acc;
    assign sub_borrow_in = 1'b0;

    // Increment is CI - (-1); negation is 0 - T; JRP adds by subtracting -T
    assign sub_a = (state == INC || state == EXEC2 || is_cmp) ? ci :
                   (state == EXEC && is_sub) ? acc : '0;
    assign sub_b = (state == INC || is_cmp) ? '1 :
                   (state == EXEC || state == EXEC2) ? t : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= HALT;
            acc          <= '0;
            ci           <= '0;
            pi           <= '0;
            t            <= '0;
            overflow_dbg <= 1'b0;
        end else begin
            case (state)
                HALT: if (run) state <= INC;
                INC: begin
                    ci    <= sub_result;
                    state <= FETCH;
                end
                FETCH: if (mem_ready) begin
                    pi    <= mem_rdata;
                    state <= fn == OP_STO ? STORE :
                             fn == OP_CMP ? EXEC :
                             fn == OP_STP ? HALT : OPER;
                end
                OPER: if (mem_ready) begin
                    if (f == OP_JMP) begin
                        ci    <= mem_rdata;
                        state <= INC;
                    end else begin
                        t     <= mem_rdata;
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    if (f == OP_JRP) t <= sub_result;
                    if (f == OP_LDN || is_sub) begin
                        acc          <= sub_result;
                        overflow_dbg <= sub_borrow_out;
                    end
                    if (f == OP_CMP && acc[DATA_W-1]) ci <= sub_result;
                    state <= f == OP_JRP ? EXEC2 : INC;
                end
                EXEC2: begin
                    ci    <= sub_result;
                    state <= INC;
                end
                STORE: if (mem_ready) state <= INC;
                default: state <= HALT;
            endcase
        end
    end
endmodule

// File: doc/baby_control_unit.md
Name: baby_control_unit

Overview:
- Fetch/decode/execute sequencer for the 32-bit Manchester Baby datapath.
- Owns the accumulator (A), the control instruction register (CI) and the present instruction register (PI), and drives a 32-word store.
- All datapath arithmetic is time-multiplexed onto one external combinational 32-bit subtractor instance (result = a - b - borrow_in).
- The block computes negation, increment and relative jump through that subtractor.

Parameters:
- ADDR_W, 5, store address width; address = CI[ADDR_W-1:0] or PI[ADDR_W-1:0].
- DATA_W, 32, word width of A, CI, PI and the subtractor.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- run  input  1  level; sampled only in HALT; 1 starts execution.
- mem_addr  output  ADDR_W  store address.
- mem_rd  output  1  read request; held with mem_addr stable until mem_ready.
- mem_wr  output  1  write request; held with mem_addr/mem_wdata stable until mem_ready.
- mem_wdata  output  DATA_W  write data (always A).
- mem_rdata  input  DATA_W  read data; valid in the cycle mem_ready=1.
- mem_ready  input  1  completes the pending access this cycle.
- sub_a  output  DATA_W  subtractor minuend.
- sub_b  output  DATA_W  subtractor subtrahend.
- sub_borrow_in  output  1  tied 0 by this block.
- sub_result  input  DATA_W  subtractor difference.
- sub_borrow_out  input  1  unused except exported on overflow_dbg.
- acc  output  DATA_W  accumulator.
- ci  output  DATA_W  control instruction register.
- halted  output  1  1 while in HALT.
- overflow_dbg  output  1  registered sub_borrow_out of the last A-writing op.

Behaviour:
- Reset (async, immediate):
  - state=HALT; A=0, CI=0, PI=0, overflow_dbg=0, halted=1.
  - mem_rd=mem_wr=0 combinationally.
  - sub_a=sub_b=0.
  - Reset mid-access abandons the access; no write completes.
- Opcode f = {PI[13], PI[14], PI[15]} read as f[0]=PI[15] (Baby bit order); operand address S = PI[4:0].
  - 0 JMP: CI=M[S]
  - 1 JRP: CI=CI+M[S]
  - 2 LDN: A=-M[S]
  - 3 STO: M[S]=A
  - 4/5 SUB: A=A-M[S]
  - 6 CMP: if A[31] then CI=CI+1
  - 7 STP: halt
- States (one subtractor op per state, result registered on the state's exit edge):
  - HALT: halted=1; if run=1, go to INC.
  - INC: sub_a=CI, sub_b=32'hFFFFFFFF; CI<=sub_result (CI+1, wraps 0xFFFFFFFF->0); go to FETCH.
  - FETCH: mem_rd, addr=CI[4:0]; on mem_ready, PI<=mem_rdata, then:
    - STO -> STORE
    - CMP -> EXEC
    - STP -> HALT
    - otherwise -> OPER
  - OPER: mem_rd, addr=S; wait mem_ready. Then:
    - JMP: CI<=mem_rdata -> INC.
    - Otherwise: T<=mem_rdata (internal operand register) -> EXEC.
  - EXEC:
    - LDN: sub 0-T -> A.
    - SUB: A-T -> A.
    - JRP: 0-T -> T, go to EXEC2.
    - CMP: sub_a=CI, sub_b=32'hFFFFFFFF; CI<=sub_result only if A[31]=1.
    - All except JRP -> INC.
  - EXEC2 (JRP only): CI - T -> CI; -> INC.
  - STORE: mem_wr, addr=S, wdata=A; on mem_ready -> INC.
- Subtractor inputs are 0 in HALT/FETCH/OPER/STORE.
- overflow_dbg updates only on LDN/SUB.
- Cycle counts with mem_ready tied 1:
  - JMP 3, JRP 5, LDN 4, STO 3, SUB 4, CMP 3.
  - STP: 2 cycles to HALT.
  - Each wait cycle on mem_ready adds 1.
- run during non-HALT states is ignored.
- STP leaves CI pointing at the STP word; a later run resumes at CI+1.
- mem_rd and mem_wr are never both 1.
- All arithmetic is modulo 2^32.

Test Plan:
- Reset then run=1, mem_ready=1, M[1]=LDN 20, M[20]=5, M[2]=STP -> after LDN completes, acc=32'hFFFFFFFB; halted=1 at cycle 6; ci=2.
- A=10 via LDN of M[20]=-10, then SUB 21 with M[21]=3 -> acc=7, overflow_dbg=0.
- Control flow:
  - CMP with A=-1 -> the next fetch skips one word (ci advances by 2).
  - CMP with A=7 -> no skip.
- Jumps:
  - JRP with CI=4, M[S]=3 -> CI=7, next fetch from address 8.
  - JMP with M[S]=9 -> next fetch from address 10.
- STO 25 with A=32'hDEADBEEF and mem_ready low for 3 cycles -> mem_wr held 4 cycles with stable addr=25 and data; a single write completes; then INC.
- Assert rst during OPER with mem_rd high:
  - mem_rd drops the same cycle; acc=0, ci=0, halted=1.
  - After release, no activity until run.
